// File: rtl/frb_trig_pkg.sv
// frb_trigger shared types: FSM state encoding and width helpers
// for the threshold product, event-length and hold-off counters.
package frb_trig_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_ACTIVE,
    ST_HOLD
  } trig_state_e;

  // avg (signed) x thresh (unsigned, one guard bit) product width
  function automatic int prod_w(input int dw, input int tw);
    return dw + tw + 1;
  endfunction

  // event length field: holds 0..max_len
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // down-counter width, never below one bit
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/align_fifo.sv
// Synchronous FIFO with async reset and registered read port.
// Ports: push/wdata in, pop/rdata out, full/empty status; ce freezes all.
module align_fifo
  import frb_trig_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

  // a full FIFO still accepts a word when the head leaves this cycle
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (ce && do_push) begin
      mem[wptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      rdata <= '0;
    end else if (ce) begin
      if (do_push) begin
        wptr <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr  <= rptr + 1'b1;
        rdata <= mem[rptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/frb_trigger.sv
// FRB threshold trigger: pairs din with its moving-average baseline, flags
// din > avg*thresh, qualifies runs and emits one record (ts/peak/len) per
// event followed by a hold-off. Ports: clk, rst, ce, din/din_valid,
// avg/avg_valid, thresh -> trig, trig_ts, trig_peak, trig_len, busy, ovf,
// unf. Define FRB_TRIG_COUNT_EN to add the trig_count output.
module frb_trigger
  import frb_trig_pkg::*;
#(
  parameter int DIN_WIDTH    = 32,
  parameter int DIN_POINT    = 31,
  parameter int THRESH_WIDTH = 16,
  parameter int THRESH_POINT = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int MIN_RUN      = 4,
  parameter int MAX_LEN      = 4096,
  parameter int HOLDOFF      = 1024,
  parameter int TS_WIDTH     = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ce,
  input  logic [DIN_WIDTH-1:0]          din,
  input  logic                          din_valid,
  input  logic [DIN_WIDTH-1:0]          avg,
  input  logic                          avg_valid,
  input  logic [THRESH_WIDTH-1:0]       thresh,
  output logic                          trig,
  output logic [TS_WIDTH-1:0]           trig_ts,
  output logic signed [DIN_WIDTH-1:0]   trig_peak,
  output logic [len_w(MAX_LEN)-1:0]     trig_len,
  output logic                          busy,
  output logic                          ovf,
  output logic                          unf
`ifdef FRB_TRIG_COUNT_EN
  ,
  output logic [31:0]                   trig_count
`endif
);

  localparam int PW = prod_w(DIN_WIDTH, THRESH_WIDTH);
  localparam int LW = len_w(MAX_LEN);
  localparam int HW = cnt_w(HOLDOFF);
  localparam logic [LW-1:0] MIN_RUN_L = LW'(MIN_RUN);
  localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);
  localparam logic [HW-1:0] HOLD_INIT =
    HW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  if (DIN_POINT >= DIN_WIDTH) begin : g_bad_point
    $error("DIN_POINT must lie inside DIN_WIDTH");
  end
  if ((FIFO_DEPTH < 8) ||
      ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and >= 8");
  end

  // ---------------- alignment FIFO ----------------
  logic [DIN_WIDTH-1:0] fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;

  align_fifo #(
    .WIDTH (DIN_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .ce    (ce),
    .push  (din_valid),
    .wdata (din),
    .pop   (avg_valid),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------- stage 1: pop / multiply ----------------
  logic                 p1_valid;
  logic signed [PW-1:0] p1_level;
  logic signed [DIN_WIDTH-1:0] p1_din;
  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] t_ext;

  assign a_ext  = PW'($signed(avg));
  assign t_ext  = PW'({1'b0, thresh});
  assign p1_din = $signed(fifo_rdata);

  // ---------------- stage 2: compare ----------------
  logic                 p2_valid;
  logic                 p2_exceed;
  logic signed [DIN_WIDTH-1:0] p2_din;
  logic signed [PW-1:0] din_ext;

  assign din_ext = PW'(p1_din) <<< THRESH_POINT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_valid  <= 1'b0;
      p1_level  <= '0;
      p2_valid  <= 1'b0;
      p2_exceed <= 1'b0;
      p2_din    <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else if (ce) begin
      // an empty pop produces no pair at all
      p1_valid  <= avg_valid && !fifo_empty;
      p1_level  <= a_ext * t_ext;
      p2_valid  <= p1_valid;
      p2_exceed <= din_ext > p1_level;
      p2_din    <= p1_din;
      if (din_valid && fifo_full && !avg_valid) begin
        ovf <= 1'b1;
      end
      if (avg_valid && fifo_empty) begin
        unf <= 1'b1;
      end
    end
  end

  // ---------------- stage 3: event FSM ----------------
  trig_state_e                 st, st_n;
  logic [TS_WIDTH-1:0]         sidx, sidx_n;
  logic [TS_WIDTH-1:0]         start, start_n;
  logic [LW-1:0]               len, len_n;
  logic signed [DIN_WIDTH-1:0] peak, peak_n;
  logic [HW-1:0]               hold, hold_n;
  logic                        trig_n;
  logic [TS_WIDTH-1:0]         ts_n;
  logic signed [DIN_WIDTH-1:0] tpk_n;
  logic [LW-1:0]               tlen_n;
  logic signed [DIN_WIDTH-1:0] pk_upd;

  assign pk_upd = (p2_din > peak) ? p2_din : peak;

  always_comb begin
    st_n    = st;
    sidx_n  = sidx;
    start_n = start;
    len_n   = len;
    peak_n  = peak;
    hold_n  = hold;
    trig_n  = 1'b0;
    ts_n    = trig_ts;
    tpk_n   = trig_peak;
    tlen_n  = trig_len;
    if (p2_valid) begin
      sidx_n = sidx + 1'b1;
      unique case (st)
        ST_IDLE: begin
          if (p2_exceed) begin
            start_n = sidx;
            len_n   = LW'(1);
            peak_n  = p2_din;
            st_n    = (MIN_RUN == 1) ? ST_ACTIVE : ST_ARM;
          end
        end
        ST_ARM: begin
          if (p2_exceed) begin
            len_n  = len + 1'b1;
            peak_n = pk_upd;
            if (len_n == MIN_RUN_L) begin
              st_n = ST_ACTIVE;
            end
          end else begin
            st_n = ST_IDLE;
          end
        end
        ST_ACTIVE: begin
          if (p2_exceed) begin
            len_n  = len + 1'b1;
            peak_n = pk_upd;
          end
          // a miss closes the event without counting itself
          if (!p2_exceed || len_n >= MAX_LEN_L) begin
            trig_n = 1'b1;
            ts_n   = start;
            tpk_n  = peak_n;
            tlen_n = len_n;
            hold_n = HOLD_INIT;
            st_n   = (HOLDOFF == 0) ? ST_IDLE : ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (hold == '0) begin
            st_n = ST_IDLE;
          end else begin
            hold_n = hold - 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= ST_IDLE;
      sidx      <= '0;
      start     <= '0;
      len       <= '0;
      peak      <= '0;
      hold      <= '0;
      trig      <= 1'b0;
      trig_ts   <= '0;
      trig_peak <= '0;
      trig_len  <= '0;
    end else if (ce) begin
      st        <= st_n;
      sidx      <= sidx_n;
      start     <= start_n;
      len       <= len_n;
      peak      <= peak_n;
      hold      <= hold_n;
      trig      <= trig_n;
      trig_ts   <= ts_n;
      trig_peak <= tpk_n;
      trig_len  <= tlen_n;
    end
  end

  assign busy = (st != ST_IDLE);

`ifdef FRB_TRIG_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_count <= '0;
    end else if (ce && trig_n) begin
      trig_count <= trig_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_frb_trigger.sv
// Self-checking bench for frb_trigger: vector table plus hand sequences,
// with a pair-level reference model feeding a trigger-record scoreboard.
module tb_frb_trigger;

  localparam int DW  = 32;
  localparam int TW  = 16;
  localparam int FD  = 8;
  localparam int MR  = 4;
  localparam int ML  = 20;
  localparam int HO  = 6;
  localparam int TSW = 32;
  localparam int LW  = $clog2(ML + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b1;
  logic signed [DW-1:0] din = '0;
  logic signed [DW-1:0] avg = '0;
  logic din_valid = 1'b0;
  logic avg_valid = 1'b0;
  logic [TW-1:0] thr = 16'h0300;
  logic trig, busy, ovf, unf;
  logic [TSW-1:0] trig_ts;
  logic signed [DW-1:0] trig_peak;
  logic [LW-1:0] trig_len;
`ifdef FRB_TRIG_COUNT_EN
  logic [31:0] trig_count;
`endif

  frb_trigger #(
    .DIN_WIDTH(DW), .DIN_POINT(31), .THRESH_WIDTH(TW),
    .THRESH_POINT(8), .FIFO_DEPTH(FD), .MIN_RUN(MR),
    .MAX_LEN(ML), .HOLDOFF(HO), .TS_WIDTH(TSW)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .din(din), .din_valid(din_valid),
    .avg(avg), .avg_valid(avg_valid),
    .thresh(thr),
    .trig(trig), .trig_ts(trig_ts),
    .trig_peak(trig_peak), .trig_len(trig_len),
    .busy(busy), .ovf(ovf), .unf(unf)
`ifdef FRB_TRIG_COUNT_EN
    , .trig_count(trig_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  int n_trig = 0;

  task automatic check(input string name,
                       input longint act,
                       input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int ts;
    logic signed [31:0] pk;
    int len;
    int at;
  } rec_t;
  rec_t exp_q[$];

  // reference model, one call per compared pair
  int m_st = 0;
  int m_run = 0;
  int m_hold = 0;
  int m_extra = 0;
  int m_start = 0;
  int m_sidx = 0;
  logic signed [31:0] m_peak = '0;

  task automatic model_pair(input logic signed [31:0] d,
                            input logic signed [31:0] a);
    bit ex;
    rec_t r;
    ex = (longint'(d) * 256) > (longint'(a) * longint'({1'b0, thr}));
    case (m_st)
      0: if (ex) begin
        m_start = m_sidx; m_run = 1; m_peak = d;
        m_st = (MR == 1) ? 2 : 1;
      end
      1: if (ex) begin
        m_run++;
        if (d > m_peak) m_peak = d;
        if (m_run == MR) m_st = 2;
      end else m_st = 0;
      2: begin
        if (ex) begin
          m_run++;
          if (d > m_peak) m_peak = d;
        end
        if (!ex || m_run == ML) begin
          r.ts = m_start; r.pk = m_peak; r.len = m_run;
          r.at = cyc + 3 + m_extra;
          exp_q.push_back(r);
          m_st = (HO == 0) ? 0 : 3;
          m_hold = HO;
        end
      end
      default: begin
        m_hold--;
        if (m_hold == 0) m_st = 0;
      end
    endcase
    m_sidx++;
  endtask

  always @(negedge clk) begin : mon
    rec_t e;
    if (!rst && trig) begin
      n_trig++;
      if (exp_q.size() == 0) begin
        check("unexpected_trig", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("trig_cycle", cyc, e.at);
        check("trig_ts", trig_ts, e.ts);
        check("trig_peak", trig_peak, e.pk);
        check("trig_len", trig_len, e.len);
      end
    end
  end

  logic signed [31:0] sq[$];
  int last_avg = 0;

  // din[i] pushed in cycle i, its avg popped in cycle i+1
  task automatic stream(input logic signed [31:0] a, input int ce_at);
    int n;
    n = sq.size();
    for (int i = 0; i <= n; i++) begin
      din_valid = (i < n);
      din = (i < n) ? sq[i] : '0;
      avg_valid = (i > 0);
      avg = a;
      m_extra = (i - 1 == ce_at) ? 5 : 0;
      if (i > 0) begin
        last_avg = cyc;
        model_pair(sq[i-1], a);
      end
      @(posedge clk); #1;
      if (i - 1 == ce_at) begin
        din_valid = 1'b0; avg_valid = 1'b0; ce = 1'b0;
        repeat (5) @(posedge clk);
        #1 ce = 1'b1;
      end
    end
    din_valid = 1'b0;
    avg_valid = 1'b0;
    m_extra = 0;
  endtask

  task automatic flush(input string name);
    repeat (10) @(posedge clk);
    #1 check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic fill(input logic signed [31:0] v, input int n);
    for (int i = 0; i < n; i++) sq.push_back(v);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_trig"}, trig, 0);
    check({tag, "_ts"}, trig_ts, 0);
    check({tag, "_peak"}, trig_peak, 0);
    check({tag, "_len"}, trig_len, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ovf"}, ovf, 0);
    check({tag, "_unf"}, unf, 0);
  endtask

  typedef struct {
    logic signed [31:0] hi;
    int n;
    logic signed [31:0] lo;
    logic signed [31:0] a;
    logic [15:0] th;
    int trigs;
    int len;
    logic signed [31:0] pk;
  } vec_t;
  vec_t vt[7];

  initial begin : wd
    #300000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    vt[0] = '{301, 4, 50, 100, 16'h0300, 1, 4, 301};
    vt[1] = '{300, 10, 50, 100, 16'h0300, 0, 0, 0};
    vt[2] = '{301, 3, 50, 100, 16'h0300, 0, 0, 0};
    vt[3] = '{-299, 5, -1000, -100, 16'h0300, 1, 5, -299};
    vt[4] = '{500, 6, 0, 400, 16'h0100, 1, 6, 500};
    vt[5] = '{1, 4, 0, 100, 16'h0000, 1, 4, 1};
    vt[6] = '{301, 7, 300, 200, 16'h0180, 1, 7, 301};

    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    foreach (vt[k]) begin
      thr = vt[k].th;
      sq.delete();
      fill(vt[k].hi, vt[k].n);
      fill(vt[k].lo, HO + 2);
      t0 = n_trig;
      stream(vt[k].a, -1);
      flush($sformatf("vec%0d_pending", k));
      check($sformatf("vec%0d_count", k), n_trig - t0, vt[k].trigs);
      check($sformatf("vec%0d_busy", k), busy, 0);
      if (vt[k].trigs > 0) begin
        check($sformatf("vec%0d_len", k), trig_len, vt[k].len);
        check($sformatf("vec%0d_peak", k), trig_peak, vt[k].pk);
      end
    end

    // length cap, then exceeding samples inside hold-off
    thr = 16'h0300;
    sq.delete();
    for (int i = 0; i < ML; i++) sq.push_back(301 + i);
    fill(400, HO);
    fill(302, 4);
    fill(50, HO + 2);
    t0 = n_trig;
    stream(100, -1);
    flush("maxlen_pending");
    check("maxlen_count", n_trig - t0, 2);
    check("maxlen_last_peak", trig_peak, 302);

    // busy rise latency, then abort of an unqualified run
    sq.delete();
    fill(301, 1);
    t0 = n_trig;
    stream(100, -1);
    while (cyc < last_avg + 2) @(negedge clk);
    check("busy_pre", busy, 0);
    @(negedge clk);
    check("busy_rise", busy, 1);
    sq.delete();
    fill(301, 2);
    fill(50, 2);
    stream(100, -1);
    flush("arm_pending");
    check("arm_no_trig", n_trig - t0, 0);
    check("arm_busy_fall", busy, 0);

    // overflow on the ninth push, underflow on an empty pop
    for (int i = 0; i < FD + 1; i++) begin
      din_valid = 1'b1;
      din = '0;
      @(posedge clk); #1;
      if (i == FD - 1) check("ovf_at_full", ovf, 0);
    end
    din_valid = 1'b0;
    check("ovf_set", ovf, 1);
    for (int i = 0; i < FD; i++) begin
      avg_valid = 1'b1;
      avg = 100;
      model_pair(0, 100);
      @(posedge clk); #1;
    end
    avg_valid = 1'b0;
    @(posedge clk); #1;
    check("unf_clear", unf, 0);
    avg_valid = 1'b1;
    @(posedge clk); #1;
    avg_valid = 1'b0;
    check("unf_set", unf, 1);
    sq = '{50, 400, 350, 320, 310, 50};
    fill(50, HO + 2);
    stream(100, -1);
    flush("unf_pending");
    check("unf_peak", trig_peak, 400);
    check("ovf_sticky", ovf, 1);

    // reset in the middle of an event
    sq.delete();
    fill(301, 5);
    stream(100, -1);
    repeat (4) @(posedge clk);
    #1 check("mid_busy", busy, 1);
    rst = 1'b1;
    #1 check_zero("midrst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_st = 0; m_sidx = 0; exp_q.delete();
    sq = '{50, 50, 301, 301, 301, 301, 50};
    fill(50, HO + 2);
    stream(100, -1);
    flush("post_rst_pending");
    check("post_rst_ts", trig_ts, 2);

    // same event with and without a clock-enable gap
    for (int r = 0; r < 2; r++) begin
      sq = '{302, 303, 305, 304, 10};
      fill(10, HO + 2);
      stream(100, (r == 1) ? 4 : -1);
      flush($sformatf("ce%0d_pending", r));
      check($sformatf("ce%0d_len", r), trig_len, 4);
      check($sformatf("ce%0d_peak", r), trig_peak, 305);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
